mic_peak_meter: RTL and testbench

//   Sits between Audio_Capture and the LED/OLED drivers. It takes the 12-bit
//   mic sample stream, finds the windowed peak, and quantises it to a 0..15

---
 rtl/mic_peak_meter.sv | 151 +++++++++++++++
 tb/tb_mic_peak_meter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_peak_meter.sv
// mic_peak_meter: windowed peak detector and 0..15 volume quantiser for the
// 12-bit mic stream, with peak-hold/decay and a 16-bit LED thermometer bar.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous active-high reset
//   sample_in    in   12  unsigned mic sample
//   sample_valid in   1   sample_in valid this cycle
//   peak         out  12  max sample of the last completed window
//   level        out  4   displayed (held/decayed) level
//   level_valid  out  1   one-cycle pulse when peak/level/led_bar update
//   led_bar      out  16  bits [level-1:0] set
module mic_peak_meter #(
    parameter int WIN_SAMPLES = 4000,
    parameter int BASELINE    = 2048,
    parameter int LVL_SHIFT   = 7,
    parameter int DECAY_EN    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] sample_in,
    input  logic        sample_valid,
    output logic [11:0] peak,
    output logic [3:0]  level,
    output logic        level_valid,
    output logic [15:0] led_bar
);

    localparam int CW = (WIN_SAMPLES > 2) ? $clog2(WIN_SAMPLES) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIN_SAMPLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [12:0]   BASE13   = 13'(BASELINE);

    localparam logic [0:0] S_ACCUM   = 1'b0;
    localparam logic [0:0] S_PUBLISH = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [11:0]   run_max_q, run_max_d;
    logic [CW-1:0] samp_cnt_q, samp_cnt_d;
    logic [11:0]   win_max_q, win_max_d;
    logic [11:0]   peak_q, peak_d;
    logic [3:0]    level_q, level_d;
    logic          level_valid_q, level_valid_d;
    logic [15:0]   led_bar_q, led_bar_d;

    logic [11:0]   samp_max;
    logic [12:0]   diff;
    logic [12:0]   shifted;
    logic [3:0]    new_lvl;
    logic [3:0]    level_nxt;
    logic [16:0]   bar_wide;

    assign samp_max = (sample_in > run_max_q) ? sample_in : run_max_q;

    // Quantise the finished window; the 13-bit subtraction is only used
    // when win_max is above the baseline, so it never wraps.
    always_comb begin
        diff    = {1'b0, win_max_q} - BASE13;
        shifted = diff >> LVL_SHIFT;
        new_lvl = 4'd0;
        if ({1'b0, win_max_q} > BASE13) begin
            if (shifted > 13'd15) begin
                new_lvl = 4'd15;
            end else begin
                new_lvl = shifted[3:0];
            end
        end
    end

    // Decay never underflows: at level 0 any new_lvl is >= level.
    always_comb begin
        level_nxt = new_lvl;
        if (DECAY_EN != 0) begin
            if (new_lvl < level_q) begin
                level_nxt = level_q - 4'd1;
            end
        end
    end

    assign bar_wide = (17'd1 << level_nxt) - 17'd1;

    always_comb begin
        state_d       = state_q;
        run_max_d     = run_max_q;
        samp_cnt_d    = samp_cnt_q;
        win_max_d     = win_max_q;
        peak_d        = peak_q;
        level_d       = level_q;
        led_bar_d     = led_bar_q;
        level_valid_d = 1'b0;
        case (state_q)
            S_ACCUM: begin
                if (sample_valid) begin
                    if (samp_cnt_q == CNT_LAST) begin
                        win_max_d  = samp_max;
                        run_max_d  = 12'd0;
                        samp_cnt_d = '0;
                        state_d    = S_PUBLISH;
                    end else begin
                        run_max_d  = samp_max;
                        samp_cnt_d = samp_cnt_q + CNT_ONE;
                    end
                end
            end
            S_PUBLISH: begin
                peak_d        = win_max_q;
                level_d       = level_nxt;
                led_bar_d     = bar_wide[15:0];
                level_valid_d = 1'b1;
                state_d       = S_ACCUM;
                // First sample of the next window may land here.
                if (sample_valid) begin
                    run_max_d  = sample_in;
                    samp_cnt_d = CNT_ONE;
                end
            end
            default: begin
                state_d = S_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_ACCUM;
            run_max_q     <= 12'd0;
            samp_cnt_q    <= '0;
            win_max_q     <= 12'd0;
            peak_q        <= 12'd0;
            level_q       <= 4'd0;
            level_valid_q <= 1'b0;
            led_bar_q     <= 16'd0;
        end else begin
            state_q       <= state_d;
            run_max_q     <= run_max_d;
            samp_cnt_q    <= samp_cnt_d;
            win_max_q     <= win_max_d;
            peak_q        <= peak_d;
            level_q       <= level_d;
            level_valid_q <= level_valid_d;
            led_bar_q     <= led_bar_d;
        end
    end

    assign peak        = peak_q;
    assign level       = level_q;
    assign level_valid = level_valid_q;
    assign led_bar     = led_bar_q;

endmodule

// File: tb/tb_mic_peak_meter.sv
// Testbench for mic_peak_meter: two instances (decay on / decay off) with
// a window-queue reference model, directed vectors and randomized traffic.
module tb_mic_peak_meter;

    localparam int WIN = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] sample_in = 12'd0;
    logic        sample_valid = 1'b0;

    logic [11:0] peak_d, peak_n;
    logic [3:0]  level_d, level_n;
    logic        lv_d, lv_n;
    logic [15:0] bar_d, bar_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mic_peak_meter #(
        .WIN_SAMPLES(WIN), .BASELINE(2048), .LVL_SHIFT(7), .DECAY_EN(1)
    ) u_dec (
        .clk(clk), .reset(reset), .sample_in(sample_in),
        .sample_valid(sample_valid), .peak(peak_d), .level(level_d),
        .level_valid(lv_d), .led_bar(bar_d)
    );

    mic_peak_meter #(
        .WIN_SAMPLES(WIN), .BASELINE(2048), .LVL_SHIFT(7), .DECAY_EN(0)
    ) u_nod (
        .clk(clk), .reset(reset), .sample_in(sample_in),
        .sample_valid(sample_valid), .peak(peak_n), .level(level_n),
        .level_valid(lv_n), .led_bar(bar_n)
    );

    function automatic logic [15:0] therm(input int lvl);
        logic [15:0] b;
        b = 16'd0;
        for (int i = 0; i < 16; i++) begin
            if (i < lvl) b[i] = 1'b1;
        end
        return b;
    endfunction

    function automatic int quant(input int pk);
        int q;
        if (pk <= 2048) return 0;
        q = (pk - 2048) / 128;
        return (q > 15) ? 15 : q;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, got, got, exp, exp, $time);
        end
    endtask

    // Reference model: collect each window's samples, publish one edge later.
    int          win_q[$];
    bit          pend;
    int          pend_pk;
    int          exp_pk, exp_ld, exp_ln;
    bit          exp_v;
    int          lv_count = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q.delete();
            pend = 0;
            exp_pk = 0; exp_ld = 0; exp_ln = 0; exp_v = 0;
        end else begin
            exp_v = 0;
            if (pend) begin
                int nl;
                nl = quant(pend_pk);
                exp_pk = pend_pk;
                exp_ln = nl;
                exp_ld = (nl >= exp_ld) ? nl : exp_ld - 1;
                exp_v = 1;
                pend = 0;
            end
            if (sample_valid) begin
                win_q.push_back(int'(sample_in));
                if (win_q.size() == WIN) begin
                    pend_pk = 0;
                    foreach (win_q[k]) if (win_q[k] > pend_pk) pend_pk = win_q[k];
                    pend = 1;
                    win_q.delete();
                end
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (!reset) begin
            int gd, ed, gn, en;
            gd = {peak_d, level_d, bar_d, lv_d};
            ed = {exp_pk[11:0], exp_ld[3:0], therm(exp_ld), exp_v};
            gn = {peak_n, level_n, bar_n, lv_n};
            en = {exp_pk[11:0], exp_ln[3:0], therm(exp_ln), exp_v};
            chk("mon_decay", gd, ed);
            chk("mon_nodecay", gn, en);
            if (lv_d) lv_count++;
        end
    end

    task automatic send(input logic [11:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_lv(input string name);
        int n;
        n = 0;
        while (!(lv_d && lv_n) && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_lv_seen"}, int'(lv_d && lv_n), 1);
    endtask

    typedef struct {
        logic [11:0] s [4];
        logic [11:0] pk;
        logic [3:0]  ld;
        logic [3:0]  ln;
        logic [15:0] bar;
    } vec_t;

    vec_t tbl [13];

    task automatic set_vec(input int i, input int a, input int b,
                           input int c, input int d, input int pk,
                           input int ld, input int ln, input int bar);
        tbl[i].s[0] = 12'(a); tbl[i].s[1] = 12'(b);
        tbl[i].s[2] = 12'(c); tbl[i].s[3] = 12'(d);
        tbl[i].pk = 12'(pk); tbl[i].ld = 4'(ld);
        tbl[i].ln = 4'(ln); tbl[i].bar = 16'(bar);
    endtask

    initial begin
        int lv_start;
        int r;

        set_vec(0, 2048, 2100, 3000, 2500, 3000, 7, 7, 'h007F);
        set_vec(1, 2048, 2048, 2048, 2048, 2048, 6, 0, 'h003F);
        set_vec(2, 2048, 2048, 2048, 2048, 2048, 5, 0, 'h001F);
        set_vec(3, 2048, 2048, 2048, 2048, 2048, 4, 0, 'h000F);
        set_vec(4, 2048, 2048, 2048, 2048, 2048, 3, 0, 'h0007);
        set_vec(5, 2048, 2048, 2048, 2048, 2048, 2, 0, 'h0003);
        set_vec(6, 2048, 2048, 2048, 2048, 2048, 1, 0, 'h0001);
        set_vec(7, 2048, 2048, 2048, 2048, 2048, 0, 0, 'h0000);
        set_vec(8, 2048, 2048, 2048, 2048, 2048, 0, 0, 'h0000);
        set_vec(9, 4095, 0, 0, 0, 4095, 15, 15, 'h7FFF);
        set_vec(10, 1000, 10, 999, 500, 1000, 14, 0, 'h3FFF);
        set_vec(11, 2200, 2176, 2175, 0, 2200, 13, 1, 'h1FFF);
        set_vec(12, 2175, 2049, 2048, 2047, 2175, 12, 0, 'h0FFF);

        #1;
        chk("rst_peak", int'(peak_d) + int'(peak_n), 0);
        chk("rst_level", int'(level_d) + int'(level_n), 0);
        chk("rst_bar", int'(bar_d) | int'(bar_n), 0);
        chk("rst_lv", int'(lv_d) + int'(lv_n), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            for (int j = 0; j < 4; j++) send(tbl[i].s[j]);
            wait_lv($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_peak", i), int'(peak_d), int'(tbl[i].pk));
            chk($sformatf("vec%0d_peak_n", i), int'(peak_n), int'(tbl[i].pk));
            chk($sformatf("vec%0d_lvl_d", i), int'(level_d), int'(tbl[i].ld));
            chk($sformatf("vec%0d_lvl_n", i), int'(level_n), int'(tbl[i].ln));
            chk($sformatf("vec%0d_bar_d", i), int'(bar_d), int'(tbl[i].bar));
            chk($sformatf("vec%0d_bar_n", i), int'(bar_n),
                int'(therm(int'(tbl[i].ln))));
        end

        // Sample presented during the PUBLISH cycle opens the next window.
        for (int j = 0; j < 4; j++) send(12'd2048);
        send(12'd3500);
        for (int j = 0; j < 3; j++) send(12'd2048);
        wait_lv("pubsamp");
        chk("pubsamp_peak", int'(peak_d), 3500);
        chk("pubsamp_lvl_n", int'(level_n), 11);
        chk("pubsamp_lvl_d", int'(level_d), 11);
        chk("pubsamp_bar_d", int'(bar_d), 'h07FF);

        // Reset in the middle of a window.
        send(12'd3000);
        send(12'd3000);
        #2 reset = 1'b1;
        #1;
        chk("midrst_peak", int'(peak_d) + int'(peak_n), 0);
        chk("midrst_level", int'(level_d) + int'(level_n), 0);
        chk("midrst_bar", int'(bar_d) | int'(bar_n), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 4; j++) send(12'd2200);
        wait_lv("postrst");
        chk("postrst_peak", int'(peak_d), 2200);
        chk("postrst_lvl_d", int'(level_d), 1);
        chk("postrst_lvl_n", int'(level_n), 1);
        chk("postrst_bar", int'(bar_d), 'h0001);
        @(negedge clk);

        // Random values and gaps, including very long idle stretches.
        lv_start = lv_count;
        for (int k = 0; k < 240; k++) begin
            r = $urandom_range(0, 3);
            case (r)
                0: send(12'($urandom_range(0, 4095)));
                1: send(12'($urandom_range(1900, 2300)));
                2: send(12'd2048);
                default: send(12'($urandom_range(2048, 4095)));
            endcase
            if (k == 37 || k == 150) begin
                repeat (5000) @(negedge clk);
            end else if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(0, 40)) @(negedge clk);
            end else begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        repeat (4) @(negedge clk);
        chk("rand_lv_count", lv_count - lv_start, 240 / WIN);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
